// File: rtl/datapath_legv8_param.sv
// Parametrised LEGv8 datapath: register file, ALU, SR/IR/PC and a
// req/ack memory port with timeout; busy freezes architectural state.
module datapath_legv8_param #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned REG_CNT        = 32,
  parameter int unsigned PC_RESET_VALUE = 0,
  parameter int unsigned TIMEOUT        = 255,
  localparam int unsigned REG_W         = $clog2(REG_CNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] constant,
  input  logic [REG_W-1:0]  DA,
  input  logic [REG_W-1:0]  SA,
  input  logic [REG_W-1:0]  SB,
  input  logic              W,
  input  logic [4:0]        FS,
  input  logic              C0,
  input  logic              Bsel,
  input  logic [1:0]        DSEL,
  input  logic              IL,
  input  logic              SL,
  input  logic [1:0]        PS,
  input  logic              ASEL,
  input  logic              mem_start,
  input  logic              mem_we,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              mem_err,
  output logic [DATA_W-1:0] data,
  output logic [3:0]        status,
  output logic [31:0]       IR_out,
  output logic [3:0]        SR_out,
  output logic [ADDR_W-1:0] PC_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [REG_W-1:0] XZR = REG_W'(REG_CNT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  rf_q [REG_CNT];
  logic [DATA_W-1:0]  rf_d [REG_CNT];
  logic               req_q, req_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [DATA_W-1:0]  mdr_q, mdr_d;
  logic [31:0]        ir_q, ir_d;
  logic [3:0]         sr_q, sr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  logic [DATA_W-1:0]  rd_a, rd_b, b_mux, a_m, b_m, f;
  logic [DATA_W:0]    sum;
  logic               v_flag, c_flag;
  logic [DATA_W-1:0]  bus;

  // Register file read ports and ALU
  always_comb begin
    rd_a   = (SA >= XZR) ? '0 : rf_q[SA];
    rd_b   = (SB >= XZR) ? '0 : rf_q[SB];
    b_mux  = Bsel ? constant : rd_b;
    a_m    = FS[1] ? ~rd_a : rd_a;
    b_m    = FS[0] ? ~b_mux : b_mux;
    sum    = {1'b0, a_m} + {1'b0, b_m} + (DATA_W + 1)'(C0);
    f      = '0;
    v_flag = 1'b0;
    c_flag = 1'b0;
    case (FS[4:2])
      3'b000: f = a_m & b_m;
      3'b001: f = a_m | b_m;
      3'b010: begin
        f      = sum[DATA_W-1:0];
        c_flag = sum[DATA_W];
        v_flag = (a_m[DATA_W-1] == b_m[DATA_W-1]) && (f[DATA_W-1] != a_m[DATA_W-1]);
      end
      3'b011: f = a_m ^ b_m;
      3'b100: f = a_m << b_m[5:0];
      3'b101: f = a_m >> b_m[5:0];
      default: f = '0;
    endcase
    status = {v_flag, c_flag, f[DATA_W-1], (f == '0)};
  end

  // Internal data bus
  always_comb begin
    case (DSEL)
      2'b00:   bus = f;
      2'b01:   bus = rd_b;
      2'b10:   bus = DATA_W'(pc_q);
      default: bus = mdr_q;
    endcase
  end

  // Next state: architectural updates gated by freeze, plus memory FSM
  always_comb begin
    state_d = state_q;
    rf_d    = rf_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    mdr_d   = mdr_q;
    ir_d    = ir_q;
    sr_d    = sr_q;
    pc_d    = pc_q;

    if (!req_q) begin
      if (W && (DA < XZR)) rf_d[DA] = bus;
      if (IL) ir_d = 32'(bus);
      if (SL) sr_d = status;
      case (PS)
        2'b01:   pc_d = pc_q + ADDR_W'(4);
        2'b10:   pc_d = rd_a[ADDR_W-1:0];
        2'b11:   pc_d = pc_q + (constant[ADDR_W-1:0] << 2);
        default: pc_d = pc_q;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (mem_start) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          wr_d    = mem_we;
          addr_d  = ASEL ? pc_q : f[ADDR_W-1:0];
          wdata_d = rd_b;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // An ack arriving on the timeout cycle still completes the transfer
        if (mem_ack) begin
          if (!wr_q) mdr_d = mem_rdata;
          state_d = S_IDLE;
          req_d   = 1'b0;
          wr_d    = 1'b0;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rf_q    <= '{default: '0};
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      sr_q    <= '0;
      pc_q    <= ADDR_W'(PC_RESET_VALUE);
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
      ir_q    <= ir_d;
      sr_q    <= sr_d;
      pc_q    <= pc_d;
    end
  end

  assign mem_req   = req_q;
  assign busy      = req_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;
  assign data      = bus;
  assign IR_out    = ir_q;
  assign SR_out    = sr_q;
  assign PC_out    = pc_q;

endmodule

// File: doc/datapath_legv8_param.md
Name: datapath_legv8_param

Overview:
Parametrised successor of the LEGv8 base datapath: register file, ALU, status register, instruction register and program counter, generalised in data/address width and register count. Tristate buses are replaced by a muxed internal data bus. A handshaked memory port (req/ack, timeout, stall) replaces the direct address/data bus. Sits between the control unit, which drives control words, and the memory/bus subsystem.

Parameters:
DATA_W, 64, datapath width (≥8, power of two)
ADDR_W, 32, address and PC width (≤DATA_W)
REG_CNT, 32, number of registers; the highest index is the zero register (XZR)
PC_RESET_VALUE, 0, PC value after reset
TIMEOUT, 255, maximum wait cycles for mem_ack before abort (≥1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
constant  in  DATA_W  immediate from control unit
DA, SA, SB  in  clog2(REG_CNT) each  destination and source register indices
W  in  1  register write enable
FS  in  5  ALU function select
C0  in  1  ALU carry-in
Bsel  in  1  ALU B source: 0 = reg B, 1 = constant
DSEL  in  2  data bus source: 00 = ALU F, 01 = reg B, 10 = zero-extended PC, 11 = MDR
IL  in  1  IR load from data[31:0]
SL  in  1  SR load from ALU status
PS  in  2  PC op: 00 hold, 01 PC+4, 10 load A[ADDR_W-1:0], 11 PC+(constant<<2)
ASEL  in  1  memory address source: 0 = F[ADDR_W-1:0], 1 = PC
mem_start  in  1  begin memory transaction (single-cycle pulse)
mem_we  in  1  transaction type: 1 = write reg B, 0 = read
mem_req  out  1  bus request
mem_wr  out  1  bus write strobe (valid while mem_req)
mem_addr  out  ADDR_W  bus address (held while mem_req)
mem_wdata  out  DATA_W  bus write data (held while mem_req)
mem_rdata  in  DATA_W  bus read data (valid with mem_ack)
mem_ack  in  1  transaction complete
busy  out  1  transaction in flight; datapath frozen
mem_err  out  1  sticky timeout flag
data  out  DATA_W  internal data bus (observation)
status  out  4  combinational ALU flags {V,C,N,Z}
IR_out  out  32  instruction register
SR_out  out  4  status register
PC_out  out  ADDR_W  program counter

Behaviour:
- Reset (async): all registers 0, PC = PC_RESET_VALUE, IR/SR/MDR 0, mem_req/mem_wr/busy/mem_err 0, FSM → IDLE, counter 0. Reset mid-transaction aborts immediately; mem_req drops asynchronously.
- Register file: two combinational read ports. A read of index REG_CNT-1 returns 0. A write on W at the clock edge stores data into DA; writes to REG_CNT-1 are discarded. Read-during-write returns the old value.
- ALU, combinational: A' = FS[1] ? ~A : A; B' = FS[0] ? ~Bmux : Bmux. FS[4:2] selects: 000 AND, 001 OR, 010 ADD (A'+B'+C0), 011 XOR, 100 A<<B[5:0], 101 A>>B[5:0] (logical). Codes 110/111 give F = 0.
- Flags: Z = (F==0); N = F[MSB]; C and V come from the ADD only and are 0 for other ops. Shift amounts ≥ DATA_W yield 0.
- PC: all arithmetic is modulo 2^ADDR_W and wraps silently. Branch offset = constant[ADDR_W-1:0] << 2.
- Freeze: while busy = 1, W, IL, SL and PS are ignored (no state changes). mem_start while busy is ignored.
- Memory FSM states:
  - IDLE: on mem_start, latch mem_addr (per ASEL), mem_wdata = reg B and mem_wr = mem_we; clear mem_err; go to WAIT. mem_req and busy are registered and assert the next cycle.
  - WAIT: mem_req = busy = 1. On mem_ack: if read, MDR ← mem_rdata; go to IDLE, so req/busy drop the following cycle. Otherwise the counter increments; when the counter reaches TIMEOUT without ack, set mem_err and go to IDLE.
  - ack in the same cycle as the timeout: ack wins, mem_err stays 0.
- Latency: minimum transaction is 2 cycles (start edge, then an ack sampled in the first WAIT cycle). MDR is usable via DSEL = 11 on the cycle after busy falls.
- The same-cycle mem_start edge still honours W/IL/SL/PS (freeze begins the next cycle).

Test Plan:
- Reset with PC_RESET_VALUE = 0x100 → PC_out = 0x100, all outputs 0. Two PS = 01 cycles → 0x108. PS = 11 with constant = −1 → 0x104.
- Write 5 to X1 and 7 to X2 (Bsel = 1, FS = ADD, DSEL = 00). Then ADD X1+X2 with SL → F = 12, SR = 0000. SUB X1−X2 (FS[0] = 1, C0 = 1) → F = −2, N = 1, C = 0.
- Write 0xFF to index 31 → reading X31 returns 0. Read-during-write of X3 returns the old value.
- Read transaction, ASEL = 0, F = 0x40; ack after 3 cycles with rdata = 0xDEAD. Require: mem_req high exactly 3 cycles, addr = 0x40, a W pulse during busy has no effect, DSEL = 11 then shows 0xDEAD.
- TIMEOUT = 4, no ack → mem_req high 4 cycles, then mem_err = 1. A following mem_start clears it.
- Assert reset during WAIT → mem_req and busy drop immediately, FSM is IDLE, and a late ack is ignored.
